// File: rtl/branch_update_fifo.sv
// Resolved-branch record FIFO between execute and the branch predictor's
// update port, with saturating resolve/mispredict statistics counters.
module branch_update_fifo #(
  parameter int DEPTH  = 4,
  parameter int ADDR_W = 32,
  parameter int CNT_W  = 32
) (
  input  logic              CLK,
  input  logic              nRST,
  input  logic              enq_valid,
  output logic              enq_ready,
  input  logic [ADDR_W-1:0] enq_pc,
  input  logic [ADDR_W-1:0] enq_target,
  input  logic              enq_taken,
  input  logic              enq_mispredict,
  output logic              upd_valid,
  input  logic              upd_ready,
  output logic [ADDR_W-1:0] upd_pc,
  output logic [ADDR_W-1:0] upd_target,
  output logic              upd_taken,
  output logic [CNT_W-1:0]  stat_resolved,
  output logic [CNT_W-1:0]  stat_mispredict
);

  localparam int              PTR_W  = $clog2(DEPTH);
  localparam logic [PTR_W:0]  C_FULL = (PTR_W + 1)'(DEPTH);
  localparam logic [CNT_W-1:0] C_SAT = '1;

  logic [ADDR_W-1:0] r_pc     [DEPTH];
  logic [ADDR_W-1:0] r_target [DEPTH];
  logic              r_taken  [DEPTH];

  logic [PTR_W-1:0]  r_rd_ptr;
  logic [PTR_W-1:0]  r_wr_ptr;
  logic [PTR_W:0]    r_count;
  logic [CNT_W-1:0]  r_stat_res;
  logic [CNT_W-1:0]  r_stat_mis;

  logic              w_enq;
  logic              w_deq;
  logic [PTR_W-1:0]  w_head_ptr;

  // Handshake status is a function of occupancy only; no full-FIFO pass-through.
  always_comb begin
    enq_ready = (r_count != C_FULL);
    upd_valid = (r_count != '0);
    w_enq     = enq_valid && enq_ready;
    w_deq     = upd_valid && upd_ready;
    // When empty, the slot behind rd_ptr still holds the last dequeued head
    // (an enqueue into an empty FIFO writes at rd_ptr, not behind it), so the
    // outputs keep showing the last head instead of a stale older entry.
    w_head_ptr = upd_valid ? r_rd_ptr : (r_rd_ptr - PTR_W'(1));
    upd_pc     = r_pc[w_head_ptr];
    upd_target = r_target[w_head_ptr];
    upd_taken  = r_taken[w_head_ptr];
  end

  // Storage array: cleared on reset, written at wr_ptr on an accepted enqueue.
  always_ff @(posedge CLK) begin
    if (nRST) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_pc[i]     <= '0;
        r_target[i] <= '0;
        r_taken[i]  <= 1'b0;
      end
    end else if (w_enq) begin
      r_pc[r_wr_ptr]     <= enq_pc;
      r_target[r_wr_ptr] <= enq_target;
      r_taken[r_wr_ptr]  <= enq_taken;
    end
  end

  // Pointers wrap naturally (DEPTH is a power of two); count tracks occupancy.
  always_ff @(posedge CLK) begin
    if (nRST) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_enq) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      if (w_deq) r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      case ({w_enq, w_deq})
        2'b10:   r_count <= r_count + (PTR_W + 1)'(1);
        2'b01:   r_count <= r_count - (PTR_W + 1)'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Saturating statistics, advanced only by accepted enqueues.
  always_ff @(posedge CLK) begin
    if (nRST) begin
      r_stat_res <= '0;
      r_stat_mis <= '0;
    end else if (w_enq) begin
      if (r_stat_res != C_SAT) r_stat_res <= r_stat_res + CNT_W'(1);
      if (enq_mispredict && (r_stat_mis != C_SAT)) r_stat_mis <= r_stat_mis + CNT_W'(1);
    end
  end

  assign stat_resolved   = r_stat_res;
  assign stat_mispredict = r_stat_mis;

endmodule

// File: tb/tb_branch_update_fifo.sv
// Bench for branch_update_fifo: directed scenarios plus randomized traffic,
// checked against a queue-based reference model. A second instance with
// 4-bit counters shares all inputs to exercise statistics saturation.
module tb_branch_update_fifo;

  localparam int DEPTH = 4;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] tgt;
    logic        tkn;
  } rec_t;

  logic        CLK;
  logic        nRST;
  logic        enq_valid;
  logic [31:0] enq_pc;
  logic [31:0] enq_target;
  logic        enq_taken;
  logic        enq_mispredict;
  logic        upd_ready;

  logic        enq_ready, upd_valid, upd_taken;
  logic [31:0] upd_pc, upd_target, stat_resolved, stat_mispredict;

  logic        s_enq_ready, s_upd_valid, s_upd_taken;
  logic [31:0] s_upd_pc, s_upd_target;
  logic [3:0]  s_stat_resolved, s_stat_mispredict;

  branch_update_fifo #(.DEPTH(DEPTH), .ADDR_W(32), .CNT_W(32)) dut (
    .CLK(CLK), .nRST(nRST),
    .enq_valid(enq_valid), .enq_ready(enq_ready),
    .enq_pc(enq_pc), .enq_target(enq_target),
    .enq_taken(enq_taken), .enq_mispredict(enq_mispredict),
    .upd_valid(upd_valid), .upd_ready(upd_ready),
    .upd_pc(upd_pc), .upd_target(upd_target), .upd_taken(upd_taken),
    .stat_resolved(stat_resolved), .stat_mispredict(stat_mispredict)
  );

  branch_update_fifo #(.DEPTH(DEPTH), .ADDR_W(32), .CNT_W(4)) dut_small (
    .CLK(CLK), .nRST(nRST),
    .enq_valid(enq_valid), .enq_ready(s_enq_ready),
    .enq_pc(enq_pc), .enq_target(enq_target),
    .enq_taken(enq_taken), .enq_mispredict(enq_mispredict),
    .upd_valid(s_upd_valid), .upd_ready(upd_ready),
    .upd_pc(s_upd_pc), .upd_target(s_upd_target), .upd_taken(s_upd_taken),
    .stat_resolved(s_stat_resolved), .stat_mispredict(s_stat_mispredict)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model state
  rec_t   mq[$];
  rec_t   m_last;
  longint m_res;
  longint m_mis;

  function automatic rec_t exp_head();
    if (mq.size() != 0) return mq[0];
    return m_last;
  endfunction

  function automatic longint sat(longint v, longint mx);
    return (v > mx) ? mx : v;
  endfunction

  // Apply the currently driven inputs to the model, then advance one clock.
  task automatic tick();
    bit   enq_f;
    bit   deq_f;
    rec_t r;
    enq_f = enq_valid && (mq.size() != DEPTH);
    deq_f = upd_ready && (mq.size() != 0);
    if (nRST) begin
      mq.delete();
      m_last = '0;
      m_res  = 0;
      m_mis  = 0;
    end else begin
      if (deq_f) begin
        m_last = mq[0];
        void'(mq.pop_front());
      end
      if (enq_f) begin
        r.pc  = enq_pc;
        r.tgt = enq_target;
        r.tkn = enq_taken;
        mq.push_back(r);
        m_res++;
        if (enq_mispredict) m_mis++;
      end
    end
    @(posedge CLK);
    #1;
  endtask

  task automatic drive_enq(bit v, logic [31:0] pc, logic [31:0] tgt, bit tkn, bit mis);
    enq_valid      = v;
    enq_pc         = pc;
    enq_target     = tgt;
    enq_taken      = tkn;
    enq_mispredict = mis;
  endtask

  task automatic do_reset();
    nRST = 1'b1;
    tick();
    nRST = 1'b0;
  endtask

  task automatic test_reset();
    nRST = 1'b1;
    upd_ready = 1'b0;
    drive_enq(1'b1, 32'hDEAD_0000, 32'hBEEF_0000, 1'b1, 1'b1);
    tick();
    tick();
    n_checks++;
    if (upd_valid !== 1'b0) $display("FAIL reset_upd_valid: got %b expected 0", upd_valid);
    else n_pass++;
    n_checks++;
    if (enq_ready !== 1'b1) $display("FAIL reset_enq_ready: got %b expected 1", enq_ready);
    else n_pass++;
    n_checks++;
    if (stat_resolved !== 32'd0 || stat_mispredict !== 32'd0)
      $display("FAIL reset_stats: got %0d/%0d expected 0/0", stat_resolved, stat_mispredict);
    else n_pass++;
    n_checks++;
    if (upd_pc !== 32'd0 || upd_target !== 32'd0 || upd_taken !== 1'b0)
      $display("FAIL reset_head: got %h/%h/%b expected 0/0/0", upd_pc, upd_target, upd_taken);
    else n_pass++;
    nRST = 1'b0;
    drive_enq(1'b0, '0, '0, 1'b0, 1'b0);
    tick();
    n_checks++;
    if (upd_valid !== 1'b0) $display("FAIL reset_no_record: got %b expected 0", upd_valid);
    else n_pass++;
  endtask

  task automatic test_single();
    do_reset();
    upd_ready = 1'b1;
    drive_enq(1'b1, 32'h100, 32'h80, 1'b1, 1'b1);
    tick();
    drive_enq(1'b0, '0, '0, 1'b0, 1'b0);
    n_checks++;
    if (upd_valid !== 1'b1 || upd_pc !== 32'h100 || upd_target !== 32'h80 || upd_taken !== 1'b1)
      $display("FAIL single_head: got v=%b pc=%h tgt=%h tk=%b expected v=1 pc=100 tgt=80 tk=1",
               upd_valid, upd_pc, upd_target, upd_taken);
    else n_pass++;
    tick();
    n_checks++;
    if (upd_valid !== 1'b0) $display("FAIL single_drained: got %b expected 0", upd_valid);
    else n_pass++;
    n_checks++;
    if (upd_pc !== 32'h100) $display("FAIL single_hold_last: got %h expected 100", upd_pc);
    else n_pass++;
    n_checks++;
    if (stat_resolved !== 32'd1 || stat_mispredict !== 32'd1)
      $display("FAIL single_stats: got %0d/%0d expected 1/1", stat_resolved, stat_mispredict);
    else n_pass++;
  endtask

  task automatic test_fill_backpressure();
    logic [31:0] pcs [5];
    logic [31:0] got [$];
    bit          ok;
    pcs = '{32'h10, 32'h14, 32'h18, 32'h1C, 32'h20};
    do_reset();
    upd_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      drive_enq(1'b1, pcs[i], pcs[i] + 32'h1000, i[0], 1'b0);
      n_checks++;
      if (enq_ready !== 1'b1) $display("FAIL fill_ready_%0d: got %b expected 1", i, enq_ready);
      else n_pass++;
      tick();
    end
    drive_enq(1'b1, pcs[4], pcs[4] + 32'h1000, 1'b0, 1'b0);
    for (int i = 0; i < 2; i++) begin
      n_checks++;
      if (enq_ready !== 1'b0) $display("FAIL fill_full_%0d: got %b expected 0", i, enq_ready);
      else n_pass++;
      tick();
    end
    upd_ready = 1'b1;
    for (int c = 0; c < 12; c++) begin
      if (upd_valid === 1'b1) got.push_back(upd_pc);
      if (enq_valid && enq_ready === 1'b1) begin
        tick();
        enq_valid = 1'b0;
      end else begin
        tick();
      end
    end
    ok = (got.size() == 5);
    if (ok) for (int i = 0; i < 5; i++) if (got[i] !== pcs[i]) ok = 0;
    n_checks++;
    if (!ok) $display("FAIL fill_drain_order: got %0d records %p expected 10,14,18,1c,20", got.size(), got);
    else n_pass++;
  endtask

  task automatic test_back_to_back();
    longint base;
    rec_t   h;
    int     drained;
    do_reset();
    upd_ready = 1'b0;
    for (int i = 0; i < 2; i++) begin
      drive_enq(1'b1, $urandom, $urandom, 1'($urandom), 1'($urandom));
      tick();
    end
    base = m_res;
    upd_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      drive_enq(1'b1, $urandom, $urandom, 1'($urandom), 1'($urandom));
      h = exp_head();
      n_checks++;
      if (enq_ready !== 1'b1 || upd_valid !== 1'b1 || upd_pc !== h.pc ||
          upd_target !== h.tgt || upd_taken !== h.tkn)
        $display("FAIL b2b_cycle_%0d: got r=%b v=%b pc=%h tgt=%h tk=%b expected r=1 v=1 pc=%h tgt=%h tk=%b",
                 i, enq_ready, upd_valid, upd_pc, upd_target, upd_taken, h.pc, h.tgt, h.tkn);
      else n_pass++;
      tick();
    end
    n_checks++;
    if (stat_resolved !== 32'(base + 10))
      $display("FAIL b2b_stat_resolved: got %0d expected %0d", stat_resolved, base + 10);
    else n_pass++;
    enq_valid = 1'b0;
    drained = 0;
    for (int c = 0; c < 6; c++) begin
      if (upd_valid === 1'b1) drained++;
      tick();
    end
    n_checks++;
    if (drained != 2) $display("FAIL b2b_occupancy: got %0d expected 2", drained);
    else n_pass++;
  endtask

  task automatic test_full_simul();
    do_reset();
    upd_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      drive_enq(1'b1, 32'h200 + 32'(i * 4), 32'h300, 1'b1, 1'b0);
      tick();
    end
    drive_enq(1'b1, 32'h2AA, 32'h2BB, 1'b0, 1'b1);
    upd_ready = 1'b1;
    n_checks++;
    if (enq_ready !== 1'b0) $display("FAIL full_simul_ready: got %b expected 0", enq_ready);
    else n_pass++;
    tick();
    n_checks++;
    if (enq_ready !== 1'b1 || upd_pc !== 32'h204)
      $display("FAIL full_simul_after: got r=%b pc=%h expected r=1 pc=204", enq_ready, upd_pc);
    else n_pass++;
    tick();
    enq_valid = 1'b0;
    n_checks++;
    if (stat_resolved !== 32'd5 || stat_mispredict !== 32'd1)
      $display("FAIL full_simul_accepted: got %0d/%0d expected 5/1", stat_resolved, stat_mispredict);
    else n_pass++;
    for (int c = 0; c < 5; c++) tick();
    n_checks++;
    if (upd_valid !== 1'b0 || upd_pc !== 32'h2AA)
      $display("FAIL full_simul_last: got v=%b pc=%h expected v=0 pc=2aa", upd_valid, upd_pc);
    else n_pass++;
  endtask

  task automatic test_random();
    rec_t h;
    do_reset();
    for (int c = 0; c < 400; c++) begin
      nRST      = ($urandom_range(0, 99) == 0);
      upd_ready = ($urandom_range(0, 3) != 0);
      drive_enq(($urandom_range(0, 2) != 0), $urandom, $urandom, 1'($urandom), 1'($urandom));
      h = exp_head();
      n_checks++;
      if (upd_valid !== (mq.size() != 0) || enq_ready !== (mq.size() != DEPTH) ||
          upd_pc !== h.pc || upd_target !== h.tgt || upd_taken !== h.tkn ||
          stat_resolved !== 32'(m_res) || stat_mispredict !== 32'(m_mis) ||
          s_upd_valid !== (mq.size() != 0) || s_upd_pc !== h.pc ||
          s_stat_resolved !== 4'(sat(m_res, 15)) || s_stat_mispredict !== 4'(sat(m_mis, 15)))
        $display("FAIL random_cycle_%0d: got v=%b r=%b pc=%h st=%0d/%0d s=%0d/%0d expected v=%b r=%b pc=%h st=%0d/%0d s=%0d/%0d",
                 c, upd_valid, enq_ready, upd_pc, stat_resolved, stat_mispredict,
                 s_stat_resolved, s_stat_mispredict, mq.size() != 0, mq.size() != DEPTH,
                 h.pc, m_res, m_mis, sat(m_res, 15), sat(m_mis, 15));
      else n_pass++;
      tick();
    end
    nRST = 1'b0;
  endtask

  task automatic test_saturation();
    do_reset();
    upd_ready = 1'b1;
    for (int i = 0; i < 20; i++) begin
      drive_enq(1'b1, 32'h4000 + 32'(i), 32'h5000, 1'b1, 1'b1);
      tick();
    end
    n_checks++;
    if (s_stat_resolved !== 4'd15 || s_stat_mispredict !== 4'd15)
      $display("FAIL sat_small: got %0d/%0d expected 15/15", s_stat_resolved, s_stat_mispredict);
    else n_pass++;
    n_checks++;
    if (stat_resolved !== 32'd20 || stat_mispredict !== 32'd20)
      $display("FAIL sat_wide: got %0d/%0d expected 20/20", stat_resolved, stat_mispredict);
    else n_pass++;
    for (int i = 0; i < 3; i++) tick();
    enq_valid = 1'b0;
    n_checks++;
    if (s_stat_resolved !== 4'd15 || s_stat_mispredict !== 4'd15)
      $display("FAIL sat_hold: got %0d/%0d expected 15/15", s_stat_resolved, s_stat_mispredict);
    else n_pass++;
  endtask

  initial begin
    nRST = 1'b1;
    upd_ready = 1'b0;
    drive_enq(1'b0, '0, '0, 1'b0, 1'b0);
    m_last = '0;
    m_res  = 0;
    m_mis  = 0;
    #1;
    test_reset();
    test_single();
    test_fill_backpressure();
    test_back_to_back();
    test_full_simul();
    test_random();
    test_saturation();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
